// File: rtl/wired_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wired_pkg                                                  |
// | Purpose : Shared mode encodings and FSM state type for the wired     |
// |           bus resolver.                                              |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package wired_pkg;

    localparam logic [1:0] MODE_WAND = 2'd0;
    localparam logic [1:0] MODE_WOR  = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;
    // 2'd3 is reserved and resolves as wired-AND.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

endpackage : wired_pkg
`default_nettype wire

// File: rtl/wired_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wired_reduce                                               |
// | Purpose : Combinational reduction of the enabled drivers.            |
// | Ports   : drv_data_i  N_DRV*WIDTH packed driver values               |
// |           drv_en_i    per-driver enable                              |
// |           mode_i      resolution mode                                |
// |           value_o     resolved value (no keeper applied)             |
// |           any_en_o    at least one driver enabled                    |
// |           multi_en_differ_o  enabled drivers disagree on some bit    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module wired_reduce
    import wired_pkg::*;
#(
    parameter int N_DRV = 4,
    parameter int WIDTH = 8
) (
    input  logic [N_DRV*WIDTH-1:0] drv_data_i,
    input  logic [N_DRV-1:0]       drv_en_i,
    input  logic [1:0]             mode_i,
    output logic [WIDTH-1:0]       value_o,
    output logic                   any_en_o,
    output logic                   multi_en_differ_o
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;

    always_comb begin
        w_and = '1;
        w_or  = '0;
        for (int i = 0; i < N_DRV; i++) begin
            if (drv_en_i[i]) begin
                w_and = w_and & drv_data_i[i*WIDTH +: WIDTH];
                w_or  = w_or  | drv_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_en_o = |drv_en_i;

    // Enabled drivers all agree exactly when AND and OR of them coincide;
    // with no driver enabled the identities differ, so gate on any_en.
    assign multi_en_differ_o = any_en_o && (w_and != w_or);

    // When TRI drivers agree, OR equals the common value.
    assign value_o = ((mode_i == MODE_WOR) || (mode_i == MODE_TRI)) ? w_or : w_and;

endmodule : wired_reduce
`default_nettype wire

// File: rtl/wired_bus_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wired_bus_resolver                                         |
// | Purpose : Registered N-driver bus resolver (WAND/WOR/TRI+keeper)     |
// |           with contention counting and persistent-contention fault.  |
// | Ports   : clk, rst (sync, active-high)                               |
// |           drv_data_i, drv_en_i, mode_i, clr_fault_i, cnt_clr_i       |
// |           bus_q_o, no_drv_o, contention_o, contention_cnt_o, fault_o |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module wired_bus_resolver
    import wired_pkg::*;
#(
    parameter int N_DRV    = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 3,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_DRV*WIDTH-1:0] drv_data_i,
    input  logic [N_DRV-1:0]       drv_en_i,
    input  logic [1:0]             mode_i,
    input  logic                   clr_fault_i,
    input  logic                   cnt_clr_i,
    output logic [WIDTH-1:0]       bus_q_o,
    output logic                   no_drv_o,
    output logic                   contention_o,
    output logic [CNT_W-1:0]       contention_cnt_o,
    output logic                   fault_o
);

    localparam int PERS_W = $clog2(HOLD_CYC + 1);
    localparam logic [PERS_W-1:0] C_PERS_LAST = PERS_W'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bus_q, bus_d;
    logic              no_drv_q, no_drv_d;
    logic              cont_q, cont_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERS_W-1:0] pers_q, pers_d;
    logic [1:0]        mode_q;

    logic [WIDTH-1:0]  w_red;
    logic              w_any_en;
    logic              w_differ;
    logic              w_cont;
    logic              w_pers_inc;
    logic [WIDTH-1:0]  w_res;

    wired_reduce #(
        .N_DRV (N_DRV),
        .WIDTH (WIDTH)
    ) u_reduce (
        .drv_data_i        (drv_data_i),
        .drv_en_i          (drv_en_i),
        .mode_i            (mode_i),
        .value_o           (w_red),
        .any_en_o          (w_any_en),
        .multi_en_differ_o (w_differ)
    );

    assign w_cont = (mode_i == MODE_TRI) && w_differ;

    // Persistence only builds over an unbroken run of contention in one
    // mode; a clear pulse or mode switch restarts it.
    assign w_pers_inc = w_cont && !clr_fault_i && (mode_i == mode_q);

    // TRI keeper: with no driver or with a conflict the bus holds.
    assign w_res = ((mode_i == MODE_TRI) && (!w_any_en || w_differ)) ? bus_q : w_red;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = ST_RESOLVE;
            ST_RESOLVE: if (w_pers_inc && (pers_q == C_PERS_LAST)) state_d = ST_FAULT;
            ST_FAULT:   if (clr_fault_i) state_d = ST_RESOLVE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next-values
    always_comb begin
        bus_d    = bus_q;
        no_drv_d = no_drv_q;
        cont_d   = cont_q;
        cnt_d    = cnt_q;
        pers_d   = '0;

        if (state_q != ST_IDLE) begin
            no_drv_d = !w_any_en;
            cont_d   = w_cont;
            bus_d    = (state_d == ST_FAULT) ? '0 : w_res;
        end

        if ((state_q == ST_RESOLVE) && w_pers_inc && (pers_q != C_PERS_LAST)) begin
            pers_d = pers_q + 1'b1;
        end

        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if ((state_q != ST_IDLE) && w_cont && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q    <= '0;
            no_drv_q <= 1'b1;
            cont_q   <= 1'b0;
            cnt_q    <= '0;
            pers_q   <= '0;
            mode_q   <= MODE_WAND;
        end else begin
            bus_q    <= bus_d;
            no_drv_q <= no_drv_d;
            cont_q   <= cont_d;
            cnt_q    <= cnt_d;
            pers_q   <= pers_d;
            mode_q   <= mode_i;
        end
    end

    assign bus_q_o          = bus_q;
    assign no_drv_o         = no_drv_q;
    assign contention_o     = cont_q;
    assign contention_cnt_o = cnt_q;
    assign fault_o          = (state_q == ST_FAULT);

endmodule : wired_bus_resolver
`default_nettype wire

// File: doc/wired_bus_resolver.md
# wired_bus_resolver

Parametrised, clocked multi-driver bus resolver that generalises wired-net resolution to N drivers of arbitrary width. Each cycle it combines enabled drivers under a run-time mode (wired-AND, wired-OR, or single-owner tri-state with a bus keeper) and registers the result. It also counts contention events and latches a fault after persistent tri-state contention. It sits between multiple bus masters and a shared net in simulation-level models and testbenches.

## Interface
- N_DRV, 4, number of drivers (≥2)
- WIDTH, 8, bus width in bits
- HOLD_CYC, 3, consecutive TRI contention cycles before FAULT (≥1)
- CNT_W, 8, contention counter width
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- drv_data  in  N_DRV*WIDTH  driver i occupies bits [i*WIDTH +: WIDTH]
- drv_en  in  N_DRV  driver i participates when 1
- mode  in  2  0=WAND, 1=WOR, 2=TRI, 3=reserved (behaves as WAND)
- clr_fault  in  1  single-cycle pulse; clears FAULT and persistence count
- cnt_clr  in  1  clears contention_cnt
- bus_q  out  WIDTH  registered resolved value
- no_drv  out  1  registered; no driver enabled last cycle
- contention  out  1  registered; TRI contention last cycle
- contention_cnt  out  CNT_W  saturating count of contention cycles
- fault  out  1  high while in FAULT

## Operation
- Combinational resolution over enabled drivers only:
  - WAND: bitwise AND; none enabled gives all ones.
  - WOR: bitwise OR; none enabled gives all zeros.
  - TRI: exactly one enabled driver gives its value. None enabled holds the previous bus_q (keeper). Two or more enabled with identical values gives that value, no contention. Two or more enabled with differing values is contention; bus_q holds.
- Contention is defined in TRI only; WAND/WOR never flag it.
- FSM states are IDLE, RESOLVE, FAULT:
  - IDLE: one cycle after reset. bus_q not updated. Transitions to RESOLVE.
  - RESOLVE: bus_q, no_drv, contention update every cycle. The persistence counter increments on each contention cycle and is zeroed on any non-contention cycle or any mode change. On reaching HOLD_CYC, go to FAULT.
  - FAULT: bus_q forced to 0, fault=1, contention_cnt still counts. Only clr_fault exits, to RESOLVE.
- contention_cnt:
  - Increments each TRI contention cycle in RESOLVE or FAULT.
  - Saturates at 2^CNT_W−1.
  - cnt_clr has priority over increment in the same cycle.
- Simultaneous events:
  - clr_fault in the same cycle as contention: clear wins. FSM goes to RESOLVE and persistence restarts at 0; this cycle's contention is still counted in contention_cnt.
  - clr_fault outside FAULT: ignored apart from zeroing the persistence counter.
- Reset mid-operation discards all state on the next edge.

## Timing
- Reset values: bus_q=0, no_drv=1, contention=0, contention_cnt=0, fault=0, FSM=IDLE, persistence=0.
- Latency is 1 cycle: inputs sampled at edge k appear on bus_q/no_drv/contention after edge k. The first valid output appears after the second edge following rst deassertion (IDLE cycle).
- fault asserts on the edge where persistence reaches HOLD_CYC, i.e. the HOLD_CYC-th consecutive contention sample.
- fault deasserts on the edge that samples clr_fault.
- Mode changes take effect on the next sample; there is no drain cycle.

## Structure
- Package wired_pkg holds: mode encoding constants (MODE_WAND, MODE_WOR, MODE_TRI) and the FSM state enum (ST_IDLE, ST_RESOLVE, ST_FAULT).
- One combinational sub-module, wired_reduce (parameters N_DRV, WIDTH):
  - inputs: drv_data, drv_en, mode
  - outputs: resolved value, any_en, multi_en_differ
- The top level holds the FSM, keeper/output registers and counters.

## Test plan
All scenarios use N_DRV=4, WIDTH=8, HOLD_CYC=3, CNT_W=8.
- Reset: hold rst 2 cycles, then release → bus_q=0x00, no_drv=1, fault=0 for the IDLE cycle; bus_q tracks inputs after the next edge.
- WAND: mode=0, en=4'b0011, d0=0xF0, d1=0x3C → bus_q=0x30 one cycle later. Then en=0 → bus_q=0xFF, no_drv=1.
- WOR: mode=1, en=4'b1001, d0=0x01, d3=0x80 → bus_q=0x81. Then en=0 → bus_q=0x00.
- TRI keeper and identical drivers: mode=2, en=4'b0100, d2=0x5A → bus_q=0x5A. Then en=0 → bus_q stays 0x5A. Then en=4'b0110 with d1=d2=0xA5 → bus_q=0xA5, contention=0.
- TRI fault: mode=2, en=4'b0011, d0=0x00, d1=0xFF for 3 cycles → contention=1 each cycle and fault=1 after the 3rd sample with bus_q=0x00. Pulse clr_fault while contention continues → fault=0 next edge, persistence restarts, contention_cnt=4.
- Counter saturation and priority: force 300 contention cycles with clr_fault pulsed every 2 cycles → contention_cnt=255 and holds. Assert cnt_clr with contention in the same cycle → contention_cnt=0.
